// File: rtl/matrix_mac_engine.sv
`default_nettype none
// ==== matrix_mac_engine : header-driven matrix multiply / add / transpose engine (rev 1.0) ====
module matrix_mac_engine #(
  parameter int TYPE_BW = 32,
  parameter int ADDR_W = 32,
  parameter int ACC_W = 2 * TYPE_BW,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               mem_opdone,
  input  logic [TYPE_BW-1:0] data_i,
  output logic [TYPE_BW-1:0] data_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [1:0]         mem_operation,
  output logic               done,
  output logic               error
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    CHECK  = 4'd2,
    LOAD_A = 4'd3,
    LOAD_B = 4'd4,
    MAC    = 4'd5,
    WRITE  = 4'd6,
    NEXT   = 4'd7,
    FINISH = 4'd8
  } state_t;

  localparam logic [1:0] MODE_MUL = 2'd0;
  localparam logic [1:0] MODE_ADD = 2'd1;
  localparam logic [1:0] MODE_TRN = 2'd2;
  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b11;
  localparam logic [TYPE_BW-1:0] ONE = TYPE_BW'(1);
  localparam logic [ADDR_W-1:0] A_BASE = BASE_ADDR + ADDR_W'(5);

  state_t state, state_n, elem_first;
  logic enable_q;
  logic [2:0] hdr_cnt;
  logic [TYPE_BW-1:0] width_a, height_a, width_b, height_b;
  logic [1:0] mode;
  logic [TYPE_BW-1:0] i, j, k, a_val, b_val, out_cols;
  logic [ACC_W-1:0] acc;
  logic [ADDR_W-1:0] b_base, c_base, req_addr;
  logic start, req_active, xfer_done, access_state, dim_err, out_zero, last_elem;

  function automatic logic [ADDR_W-1:0] aw(input logic [TYPE_BW-1:0] v);
    return ADDR_W'(v);
  endfunction

  assign start        = enable && !enable_q;
  assign req_active   = (mem_operation != OP_NONE);
  assign xfer_done    = req_active && mem_opdone;
  assign access_state = (state == FETCH) || (state == LOAD_A) || (state == LOAD_B) || (state == WRITE);
  assign dim_err      = (mode == 2'd3)
                     || ((mode == MODE_MUL) && (width_a != height_b))
                     || ((mode == MODE_ADD) && ((width_a != width_b) || (height_a != height_b)));
  assign out_cols     = (mode == MODE_MUL) ? width_b : width_a;
  assign out_zero     = (height_a == '0) || (out_cols == '0);
  assign last_elem    = (i == height_a - ONE) && (j == out_cols - ONE);
  // An empty inner dimension still produces a (zero) result element.
  assign elem_first   = ((mode == MODE_MUL) && (width_a == '0)) ? WRITE : LOAD_A;

  always_comb begin
    req_addr = '0;
    case (state)
      FETCH:  req_addr = BASE_ADDR + ADDR_W'(hdr_cnt);
      LOAD_A: req_addr = A_BASE + aw(i) * aw(width_a) + aw((mode == MODE_MUL) ? k : j);
      LOAD_B: req_addr = (mode == MODE_MUL) ? b_base + aw(k) * aw(width_b) + aw(j)
                                            : b_base + aw(i) * aw(width_b) + aw(j);
      WRITE:  req_addr = (mode == MODE_TRN) ? c_base + aw(j) * aw(height_a) + aw(i)
                                            : c_base + aw(i) * aw(out_cols) + aw(j);
      default: req_addr = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (start) state_n = FETCH;
      FETCH:  if (xfer_done && (hdr_cnt == 3'd4)) state_n = CHECK;
      CHECK:  state_n = (dim_err || out_zero) ? FINISH : elem_first;
      LOAD_A: if (xfer_done) state_n = (mode == MODE_TRN) ? WRITE : LOAD_B;
      LOAD_B: if (xfer_done) state_n = (mode == MODE_MUL) ? MAC : WRITE;
      MAC:    state_n = (k + ONE == width_a) ? WRITE : LOAD_A;
      WRITE:  if (xfer_done) state_n = NEXT;
      NEXT:   state_n = last_elem ? FINISH : elem_first;
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      enable_q      <= 1'b0;
      hdr_cnt       <= '0;
      width_a       <= '0;
      height_a      <= '0;
      width_b       <= '0;
      height_b      <= '0;
      mode          <= '0;
      i             <= '0;
      j             <= '0;
      k             <= '0;
      a_val         <= '0;
      b_val         <= '0;
      acc           <= '0;
      b_base        <= '0;
      c_base        <= '0;
      mem_operation <= OP_NONE;
      addr_o        <= '0;
      data_o        <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      state    <= state_n;
      enable_q <= enable;
      // Requests go out one cycle after the bus is seen idle, so a gap cycle always separates them.
      if (access_state && !req_active) begin
        mem_operation <= (state == WRITE) ? OP_WRITE : OP_READ;
        addr_o        <= req_addr;
        if (state == WRITE) data_o <= TYPE_BW'(acc);
      end
      if (xfer_done) mem_operation <= OP_NONE;
      case (state)
        IDLE: if (start) begin
          done    <= 1'b0;
          error   <= 1'b0;
          hdr_cnt <= '0;
          i       <= '0;
          j       <= '0;
          k       <= '0;
          acc     <= '0;
        end
        FETCH: if (xfer_done) begin
          case (hdr_cnt)
            3'd0:    width_a  <= data_i;
            3'd1:    height_a <= data_i;
            3'd2:    width_b  <= data_i;
            3'd3:    height_b <= data_i;
            default: mode     <= data_i[1:0];
          endcase
          hdr_cnt <= hdr_cnt + 3'd1;
        end
        CHECK: begin
          b_base <= A_BASE + aw(height_a) * aw(width_a);
          c_base <= A_BASE + aw(height_a) * aw(width_a) + aw(height_b) * aw(width_b);
        end
        LOAD_A: if (xfer_done) begin
          a_val <= data_i;
          if (mode == MODE_TRN) acc <= ACC_W'(data_i);
        end
        LOAD_B: if (xfer_done) begin
          if (mode == MODE_MUL) b_val <= data_i;
          else acc <= ACC_W'(a_val) + ACC_W'(data_i);
        end
        MAC: begin
          acc <= acc + ACC_W'(a_val) * ACC_W'(b_val);
          k   <= k + ONE;
        end
        NEXT: begin
          k   <= '0;
          acc <= '0;
          if (j == out_cols - ONE) begin
            j <= '0;
            i <= i + ONE;
          end else begin
            j <= j + ONE;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          error <= dim_err;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_mac_engine.sv
`default_nettype none
// ==== tb_matrix_mac_engine : job table against a word-memory model with a write scoreboard (rev 1.0) ====
module tb_matrix_mac_engine;

  logic        clk;
  logic        reset, enable, mem_opdone;
  logic [31:0] data_i, data_o, addr_o;
  logic [1:0]  mem_operation;
  logic        done, error;

  logic       enable8, opdone8, done8, error8;
  logic [7:0] data8_i, data8_o, addr8;
  logic [1:0] op8;

  matrix_mac_engine u_dut (
    .clk(clk), .reset(reset), .enable(enable), .mem_opdone(mem_opdone),
    .data_i(data_i), .data_o(data_o), .addr_o(addr_o),
    .mem_operation(mem_operation), .done(done), .error(error)
  );

  matrix_mac_engine #(.TYPE_BW(8), .ADDR_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable8), .mem_opdone(opdone8),
    .data_i(data8_i), .data_o(data8_o), .addr_o(addr8),
    .mem_operation(op8), .done(done8), .error(error8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned mode, wa, ha, wb, hb, a0, astep, b0, bstep;
    bit          err;
    int          reads;
    int          nc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  vec_t        tv[9];
  int unsigned exp_c[9][6];
  wr_t         exp_q[$];
  logic [31:0] mem[64];
  logic [7:0]  mem8[16];

  int  tests, failed;
  int  reads, writes, w8_cnt;
  int  max_lat, lat, hit;
  bit  noise, stall_writes, stable_ok;
  logic [1:0]  prev_op;
  logic [31:0] prev_addr, prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int unsigned m, wa, ha, wb, hb, a0, astep, b0, bstep,
                              input bit err, input int rd, input int nc);
    vec_t v;
    v.mode = m; v.wa = wa; v.ha = ha; v.wb = wb; v.hb = hb;
    v.a0 = a0; v.astep = astep; v.b0 = b0; v.bstep = bstep;
    v.err = err; v.reads = rd; v.nc = nc;
    return v;
  endfunction

  // Memory responder: random latency, optional stray strobes while idle, write-stall for reset tests.
  initial begin
    mem_opdone = 1'b0;
    data_i     = '0;
    lat        = 0;
    stable_ok  = 1'b1;
    prev_op    = 2'b00;
    forever begin
      @(negedge clk);
      mem_opdone = 1'b0;
      data_i     = $urandom;
      if (reset || mem_operation == 2'b00) begin
        lat       = $urandom_range(0, max_lat);
        stable_ok = 1'b1;
        prev_op   = 2'b00;
        if (noise && !reset && ($urandom_range(0, 2) == 0)) mem_opdone = 1'b1;
      end else begin
        if (prev_op != 2'b00 && (mem_operation != prev_op || addr_o != prev_addr ||
            (mem_operation == 2'b11 && data_o != prev_data)))
          stable_ok = 1'b0;
        prev_op   = mem_operation;
        prev_addr = addr_o;
        prev_data = data_o;
        if (!(stall_writes && mem_operation == 2'b11)) begin
          if (lat > 0) begin
            lat--;
          end else begin
            mem_opdone = 1'b1;
            check("req_stable", {63'd0, stable_ok}, 64'd1);
            if (mem_operation == 2'b01) begin
              data_i = mem[addr_o[5:0]];
              reads++;
            end else begin
              mem[addr_o[5:0]] = data_o;
              writes++;
              hit = -1;
              foreach (exp_q[q]) if (hit < 0 && exp_q[q].addr == addr_o) hit = q;
              check("write_addr_expected", {63'd0, hit >= 0}, 64'd1);
              if (hit >= 0) begin
                check("write_data", {32'd0, data_o}, {32'd0, exp_q[hit].data});
                exp_q.delete(hit);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    opdone8 = 1'b0;
    data8_i = '0;
    forever begin
      @(negedge clk);
      opdone8 = 1'b0;
      data8_i = 8'h00;
      if (!reset && op8 != 2'b00) begin
        opdone8 = 1'b1;
        if (op8 == 2'b01) data8_i = mem8[addr8[3:0]];
        else begin
          mem8[addr8[3:0]] = data8_o;
          w8_cnt++;
        end
      end
    end
  end

  task automatic load_vec(input int idx);
    int unsigned na, nb, cbase;
    vec_t v;
    wr_t  w;
    v = tv[idx];
    for (int n = 0; n < 64; n++) mem[n] = 32'hA5A5_0000 | n;
    mem[0] = v.wa; mem[1] = v.ha; mem[2] = v.wb; mem[3] = v.hb; mem[4] = v.mode;
    na = v.ha * v.wa;
    nb = v.hb * v.wb;
    for (int n = 0; n < int'(na); n++) mem[5 + n] = v.a0 + n * v.astep;
    for (int n = 0; n < int'(nb); n++) mem[5 + na + n] = v.b0 + n * v.bstep;
    cbase = 5 + na + nb;
    exp_q.delete();
    for (int n = 0; n < v.nc; n++) begin
      w.addr = cbase + n;
      w.data = exp_c[idx][n];
      exp_q.push_back(w);
    end
    reads  = 0;
    writes = 0;
  endtask

  task automatic wait_job(input int idx, input bit toggle_en);
    bit got;
    got = 1'b0;
    @(negedge clk);
    check("start_clears_flags", {62'd0, done, error}, 64'd0);
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (toggle_en && c == 20) enable = 1'b0;
      if (toggle_en && c == 22) enable = 1'b1;
      @(negedge clk);
    end
    check("job_done", {63'd0, got}, 64'd1);
    check("error_flag", {63'd0, error}, {63'd0, tv[idx].err});
    check("read_count", 64'(reads), 64'(tv[idx].reads));
    check("write_count", 64'(writes), 64'(tv[idx].nc));
    check("writes_outstanding", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("held_after_done", {60'd0, done, error, mem_operation}, {60'd0, 1'b1, tv[idx].err, 2'b00});
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input bit toggle_en);
    load_vec(idx);
    @(negedge clk);
    enable = 1'b1;
    wait_job(idx, toggle_en);
  endtask

  initial begin
    bit got;
    tests = 0; failed = 0; reads = 0; writes = 0; w8_cnt = 0;
    max_lat = 0; noise = 1'b0; stall_writes = 1'b0;
    reset = 1'b1; enable = 1'b0; enable8 = 1'b0;

    //        mode wa ha wb hb a0 as b0 bs  err reads nc
    tv[0] = mk(0,   2, 2, 2, 2, 1, 1, 5, 1,  0, 21,  4);
    tv[1] = mk(1,   3, 2, 3, 2, 1, 1, 10, 10, 0, 17, 6);
    tv[2] = mk(6,   3, 2, 0, 0, 1, 1, 0, 0,  0, 11,  6);
    tv[3] = mk(0,   3, 2, 2, 2, 1, 1, 1, 1,  1, 5,   0);
    tv[4] = mk(3,   2, 2, 2, 2, 1, 1, 1, 1,  1, 5,   0);
    tv[5] = mk(1,   2, 2, 2, 3, 1, 1, 1, 1,  1, 5,   0);
    tv[6] = mk(0,   3, 0, 2, 3, 1, 1, 1, 1,  0, 5,   0);
    tv[7] = mk(0,   3, 1, 1, 3, 1, 1, 4, 1,  0, 11,  1);
    tv[8] = mk(0,   0, 1, 2, 0, 0, 0, 0, 0,  0, 5,   2);
    exp_c = '{'{19, 22, 43, 50, 0, 0}, '{11, 22, 33, 44, 55, 66}, '{1, 4, 2, 5, 3, 6},
              '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0},
              '{0, 0, 0, 0, 0, 0}, '{32, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0}};
    mem8 = '{8'd2, 8'd1, 8'd1, 8'd2, 8'd0, 8'd200, 8'd100, 8'd200, 8'd100,
             8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE};

    repeat (3) @(negedge clk);
    check("rst_mem_operation", {62'd0, mem_operation}, 64'd0);
    check("rst_addr", {32'd0, addr_o}, 64'd0);
    check("rst_data", {32'd0, data_o}, 64'd0);
    check("rst_done_error", {62'd0, done, error}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int pass = 0; pass < 2; pass++) begin
      max_lat = (pass == 0) ? 0 : 7;
      noise   = (pass == 1);
      for (int v = 0; v < 9; v++) run_vec(v, 1'b0);
    end

    // Enable re-edge in the middle of a job must not launch a second one.
    run_vec(0, 1'b1);

    // Reset while a write is held on the bus, then a clean rerun.
    load_vec(0);
    stall_writes = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (mem_operation == 2'b11) begin
        got = 1'b1;
        break;
      end
    end
    check("write_request_seen", {63'd0, got}, 64'd1);
    repeat (3) @(negedge clk);
    check("write_still_held", {62'd0, mem_operation}, 64'h3);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_mem_operation", {62'd0, mem_operation}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_addr", {32'd0, addr_o}, 64'd0);
    reset = 1'b0;
    enable = 1'b0;
    stall_writes = 1'b0;
    @(negedge clk);
    run_vec(0, 1'b0);

    // Enable held high across reset release starts a job.
    load_vec(7);
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_job(7, 1'b0);

    // Narrow instance: 200*200 + 100*100 wraps to 0x50 in the low 8 bits.
    w8_cnt = 0;
    @(negedge clk);
    enable8 = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (done8) begin
        got = 1'b1;
        break;
      end
    end
    check("ovf_done", {63'd0, got}, 64'd1);
    check("ovf_error", {63'd0, error8}, 64'd0);
    check("ovf_data", {56'd0, mem8[9]}, 64'h50);
    check("ovf_writes", 64'(w8_cnt), 64'd1);
    enable8 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected all jobs to finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
